fetch_stage: RTL



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/imem16x8.sv | 25 ++
 rtl/fetch_stage.sv | 82 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 2-stage 4-bit CPU.
package cpu_pkg;

    localparam int PC_W   = 4;
    localparam int INSN_W = 8;
    localparam int MEM_DEPTH = 1 << PC_W;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INSN_W-1:0] insn_t;

    localparam logic [3:0] OP_JMP = 4'hF;
    localparam logic [3:0] OP_JNC = 4'hE;

    // ADD A,#0: leaves A unchanged and clears carry, so it is a safe bubble.
    localparam insn_t NOP_INSN_DEFAULT = 8'h00;

    function automatic logic [3:0] opcode(input insn_t insn);
        return insn[INSN_W-1:INSN_W-4];
    endfunction

    function automatic pc_t immediate(input insn_t insn);
        return insn[PC_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, programming and instruction-bus signals between the core and fetch.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic  cflag;
    logic  run;
    logic  prog_en;
    logic  prog_we;
    pc_t   prog_addr;
    insn_t prog_data;
    insn_t D_BUS;
    pc_t   pc;
    logic  halted;

    modport master (
        output cflag, run, prog_en, prog_we, prog_addr, prog_data,
        input  D_BUS, pc, halted
    );

    modport slave (
        input  cflag, run, prog_en, prog_we, prog_addr, prog_data,
        output D_BUS, pc, halted
    );

endinterface

// File: rtl/imem16x8.sv
// 16x8 instruction memory: synchronous write, asynchronous read.
module imem16x8
    import cpu_pkg::*;
(
    input  logic  clock,
    input  logic  we,
    input  pc_t   waddr,
    input  insn_t wdata,
    input  pc_t   raddr,
    output insn_t rdata
);

    // NOTE: the array has no reset; program contents must survive a core reset.
    insn_t mem_q [MEM_DEPTH];

    // Write port, used only while the core is held in programming mode.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, instruction register and branch resolution.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter insn_t NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    pc_t   pc_q, pc_d;
    insn_t ir_q, ir_d;
    pc_t   ir_pc_q, ir_pc_d;
    logic  halted_q, halted_d;

    insn_t mem_rdata;
    logic  taken;
    logic  self_jmp;

    imem16x8 u_imem (
        .clock (clock),
        .we    (bus.prog_en & bus.prog_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (mem_rdata)
    );

    // Branch decode from the instruction register; cflag belongs to the preceding instruction.
    always_comb begin
        taken    = (opcode(ir_q) == OP_JMP) ||
                   ((opcode(ir_q) == OP_JNC) && !bus.cflag);
        self_jmp = (opcode(ir_q) == OP_JMP) && (immediate(ir_q) == ir_pc_q);
    end

    // Next-state selection: programming, then redirect, then stall, then sequential fetch.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        halted_d = halted_q | self_jmp;

        if (bus.prog_en) begin
            pc_d     = '0;
            ir_d     = NOP_INSN;
            halted_d = 1'b0;
        end else if (taken) begin
            // Squash the wrong-path slot and redirect, whether or not run is high.
            pc_d = immediate(ir_q);
            ir_d = NOP_INSN;
        end else if (!bus.run) begin
            ir_d = NOP_INSN;
        end else begin
            ir_d    = mem_rdata;
            ir_pc_d = pc_q;
            pc_d    = pc_q + pc_t'(1);
        end
    end

    // State registers with synchronous reset; reset overrides any pending redirect.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= NOP_INSN;
            ir_pc_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            halted_q <= halted_d;
        end
    end

    assign bus.D_BUS  = ir_q;
    assign bus.pc     = pc_q;
    assign bus.halted = halted_q;

endmodule
